apb_i2c_regif: RTL and testbench

APB_I2C_REGIF -- requirements
Module: apb_i2c_regif

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_xfer_ctrl.sv | 67 ++++++
 rtl/apb_i2c_regif.sv | 132 +++++++++++++
 tb/tb_apb_i2c_regif.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared register map, bit positions, FSM encoding and timeout for the APB I2C register interface
package i2c_pkg;

    localparam logic [7:0] ADDR_CON1   = 8'h00;
    localparam logic [7:0] ADDR_CON2   = 8'h04;
    localparam logic [7:0] ADDR_TXDATA = 8'h08;
    localparam logic [7:0] ADDR_RXDATA = 8'h0C;
    localparam logic [7:0] ADDR_STAT   = 8'h10;
    localparam logic [7:0] ADDR_CMD    = 8'h14;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_ERR        = 2;
    localparam int STAT_MIRROR_LSB = 8;

    localparam int CMD_GO = 0;
    localparam int CMD_IE = 1;

    // Bit of CON1 that starts the bridge; only passed through while in START.
    localparam int CON1_EN = 1;

    // Consecutive ready=1 cycles in WAIT_ACK before the transfer is abandoned.
    localparam int         TIMEOUT_CYCLES = 256;
    localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4
    } xfer_state_t;

endpackage

// File: rtl/i2c_xfer_ctrl.sv
// rtl/i2c_xfer_ctrl.sv - transfer sequencer handshaking with the I2C bridge ready line
module i2c_xfer_ctrl
    import i2c_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        ready,
    output xfer_state_t state,
    output logic        busy,
    output logic        set_done,
    output logic        set_err
);

    xfer_state_t next_state;
    logic [7:0]  count;
    logic [7:0]  next_count;

    // State and timeout counter registers; reset drops straight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic; the counter restarts on the way into WAIT_ACK and its terminal value ends the wait with ERR.
    always_comb begin
        next_state = state;
        next_count = count;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) next_state = ST_START;
            end
            ST_START: begin
                next_state = ST_WAIT_ACK;
                next_count = '0;
            end
            ST_WAIT_ACK: begin
                if (!ready) begin
                    next_state = ST_WAIT_DONE;
                end else if (count == TIMEOUT_LAST) begin
                    set_err    = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_count = count + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (ready) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                set_done   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/apb_i2c_regif.sv
// rtl/apb_i2c_regif.sv - APB3 register file and decode in front of the I2C bridge
module apb_i2c_regif
    import i2c_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  i2c_con1,
    output logic [7:0]  i2c_con2,
    output logic [31:0] Din,
    input  logic [31:0] Dout,
    input  logic [7:0]  i2c_stat,
    input  logic        ready,
    output logic        irq
);

    logic [7:0]  con1;
    logic [7:0]  con2;
    logic [31:0] txdata;
    logic [31:0] rxdata;
    logic        done;
    logic        err;
    logic        ie;

    xfer_state_t state;
    logic        busy;
    logic        set_done;
    logic        set_err;

    logic [7:0]  addr;
    logic        addr_unused;
    logic        access;
    logic        sel_con1, sel_con2, sel_tx, sel_rx, sel_stat, sel_cmd, mapped;
    logic        wr_blocked;
    logic        wr_ok;
    logic        go;

    // Byte lanes within a word are not decoded.
    assign addr        = {PADDR[7:2], 2'b00};
    assign addr_unused = ^PADDR[1:0];
    assign access      = PSEL & PENABLE;

    assign sel_con1 = (addr == ADDR_CON1);
    assign sel_con2 = (addr == ADDR_CON2);
    assign sel_tx   = (addr == ADDR_TXDATA);
    assign sel_rx   = (addr == ADDR_RXDATA);
    assign sel_stat = (addr == ADDR_STAT);
    assign sel_cmd  = (addr == ADDR_CMD);
    assign mapped   = sel_con1 | sel_con2 | sel_tx | sel_rx | sel_stat | sel_cmd;

    // Registers that feed an in-flight transfer are frozen while busy.
    assign wr_blocked = sel_rx | (busy & (sel_con1 | sel_con2 | sel_tx | (sel_cmd & PWDATA[CMD_GO])));
    assign PSLVERR    = access & (~mapped | (PWRITE & wr_blocked));
    assign wr_ok      = access & PWRITE & mapped & ~wr_blocked;
    assign go         = wr_ok & sel_cmd & PWDATA[CMD_GO];
    assign PREADY     = 1'b1;

    i2c_xfer_ctrl u_xfer_ctrl (
        .clk      (PCLK),
        .rst      (PRESET),
        .go       (go),
        .ready    (ready),
        .state    (state),
        .busy     (busy),
        .set_done (set_done),
        .set_err  (set_err)
    );

    // Read mux, driven only during a read access phase.
    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            if (sel_con1) PRDATA[7:0] = con1;
            if (sel_con2) PRDATA[7:0] = con2;
            if (sel_tx)   PRDATA      = txdata;
            if (sel_rx)   PRDATA      = rxdata;
            if (sel_stat) begin
                PRDATA[STAT_BUSY]               = busy;
                PRDATA[STAT_DONE]               = done;
                PRDATA[STAT_ERR]                = err;
                PRDATA[STAT_MIRROR_LSB +: 8]    = i2c_stat;
            end
            if (sel_cmd)  PRDATA[CMD_IE] = ie;
        end
    end

    // Register file; hardware sets of DONE/ERR take priority over software clears.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            con1   <= '0;
            con2   <= '0;
            txdata <= '0;
            rxdata <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            ie     <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ok && sel_con1) con1   <= PWDATA[7:0];
            if (wr_ok && sel_con2) con2   <= PWDATA[7:0];
            if (wr_ok && sel_tx)   txdata <= PWDATA;
            if (wr_ok && sel_cmd)  ie     <= PWDATA[CMD_IE];
            if (set_done)          rxdata <= Dout;
            if (set_done)
                done <= 1'b1;
            else if (go || (wr_ok && sel_stat && PWDATA[STAT_DONE]))
                done <= 1'b0;
            if (set_err)
                err <= 1'b1;
            else if (go || (wr_ok && sel_stat && PWDATA[STAT_ERR]))
                err <= 1'b0;
            irq <= ie & (done | err);
        end
    end

    // Enable bit reaches the bridge only during the single START cycle.
    always_comb begin
        i2c_con1          = con1;
        i2c_con1[CON1_EN] = con1[CON1_EN] & (state == ST_START);
    end

    assign i2c_con2 = con2;
    assign Din      = txdata;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// tb/tb_apb_i2c_regif.sv - randomized self-checking bench for apb_i2c_regif
module tb_apb_i2c_regif;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  i2c_con1;
    logic [7:0]  i2c_con2;
    logic [31:0] Din;
    logic [31:0] Dout = '0;
    logic [7:0]  i2c_stat = '0;
    logic        ready = 1'b1;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;

    logic [7:0]  m_con1, m_con2;
    logic [31:0] m_tx, m_rx;
    logic        m_done, m_err, m_ie, m_busy;

    apb_i2c_regif dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .i2c_con1 (i2c_con1),
        .i2c_con2 (i2c_con2),
        .Din      (Din),
        .Dout     (Dout),
        .i2c_stat (i2c_stat),
        .ready    (ready),
        .irq      (irq)
    );

    always #5 PCLK = ~PCLK;

    // Count cycles in which the bridge sees the enable bit high.
    always @(negedge PCLK) if (i2c_con1[1]) en_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_con1 = '0; m_con2 = '0; m_tx = '0; m_rx = '0;
        m_done = 1'b0; m_err = 1'b0; m_ie = 1'b0; m_busy = 1'b0;
    endfunction

    function automatic logic model_write(input logic [7:0] a, input logic [31:0] d);
        int  w;
        logic e;
        w = int'(a[7:2]);
        e = (w > 5) || (w == 3) || (m_busy && (w <= 2 || (w == 5 && d[0])));
        if (!e) begin
            case (w)
                0: m_con1 = d[7:0];
                1: m_con2 = d[7:0];
                2: m_tx   = d;
                4: begin
                    if (d[1]) m_done = 1'b0;
                    if (d[2]) m_err  = 1'b0;
                end
                5: begin
                    m_ie = d[1];
                    if (d[0]) begin
                        m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, output logic e);
        logic [31:0] d;
        d = '0;
        e = 1'b0;
        case (int'(a[7:2]))
            0: d = {24'b0, m_con1};
            1: d = {24'b0, m_con2};
            2: d = m_tx;
            3: d = m_rx;
            4: d = {16'b0, i2c_stat, 5'b0, m_err, m_done, m_busy};
            5: d = {30'b0, m_ie, 1'b0};
            default: e = 1'b1;
        endcase
        return d;
    endfunction

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 e = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin d = PRDATA; e = PSLVERR; end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d);
        logic exp_e, got_e;
        exp_e = model_write(a, d);
        apb_write(a, d, got_e);
        check({tag, "_slverr"}, 32'(got_e), 32'(exp_e));
    endtask

    task automatic do_read(input string tag, input logic [7:0] a);
        logic [31:0] exp_d, got_d;
        logic exp_e, got_e;
        exp_d = model_read(a, exp_e);
        apb_read(a, got_d, got_e);
        check({tag, "_data"}, got_d, exp_d);
        check({tag, "_slverr"}, 32'(got_e), 32'(exp_e));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_con1"}, 32'(i2c_con1), 32'(m_con1 & 8'hFD));
        check({tag, "_con2"}, 32'(i2c_con2), 32'(m_con2));
        check({tag, "_din"}, Din, m_tx);
        check({tag, "_irq"}, 32'(irq), 32'(m_ie & (m_done | m_err)));
    endtask

    // One bridge handshake: ready drops d1 cycles after GO, returns d2 cycles later with dat.
    task automatic run_xfer(input int d1, input int d2, input logic [31:0] dat);
        int e0;
        e0 = en_cnt;
        do_write("go", 8'h14, {30'b0, m_ie, 1'b1});
        repeat (d1) @(negedge PCLK);
        ready = 1'b0;
        do_write("tx_busy", 8'h08, 32'h1);
        do_read("stat_busy", 8'h10);
        do_read("tx_kept", 8'h08);
        repeat (d2) @(negedge PCLK);
        Dout = dat;
        ready = 1'b1;
        repeat (4) @(negedge PCLK);
        m_busy = 1'b0; m_rx = dat; m_done = 1'b1;
        check("en_pulse", 32'(en_cnt - e0), 32'd1);
        do_read("rx", 8'h0C);
        do_read("stat_done", 8'h10);
        check_outputs("xfer");
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        int e0;

        model_reset();
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        check("rst_irq", 32'(irq), 32'd0);
        check("rst_slverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("pready", 32'(PREADY), 32'd1);
        for (int i = 0; i <= 20; i += 4) do_read("rst_rd", 8'(i));
        do_read("rst_unmapped", 8'h18);
        check_outputs("rst");

        do_write("con1", 8'h00, 32'hDF);
        do_write("con2", 8'h04, 32'hCB);
        do_write("tx", 8'h08, 32'h0000FEAB);
        do_write("ie", 8'h14, 32'h2);
        run_xfer(3, 40, 32'h12345678);

        for (int it = 0; it < 40; it++) begin
            i2c_stat = 8'($urandom);
            a = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 8'hFC;
            d = $urandom;
            if (a[7:2] == 6'd5) d[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) do_write("rnd_wr", a, d);
            else                          do_read("rnd_rd", a);
            do_read("rnd_chk", 8'($urandom_range(0, 5) * 4));
            check_outputs("rnd");
        end

        for (int it = 0; it < 4; it++) begin
            do_write("x_con1", 8'h00, $urandom | 32'h2);
            do_write("x_tx", 8'h08, $urandom);
            do_write("x_ie", 8'h14, {30'b0, 1'($urandom), 1'b0});
            run_xfer($urandom_range(0, 10), $urandom_range(1, 30), $urandom);
        end

        i2c_stat = 8'h00;
        do_write("to_ie", 8'h14, 32'h2);
        e0 = en_cnt;
        do_write("to_go", 8'h14, 32'h3);
        repeat (248) @(negedge PCLK);
        do_read("to_still_busy", 8'h10);
        repeat (10) @(negedge PCLK);
        m_busy = 1'b0; m_err = 1'b1;
        do_read("to_err", 8'h10);
        check("to_en_pulse", 32'(en_cnt - e0), 32'd1);
        check_outputs("to");
        do_write("to_clr", 8'h10, 32'h4);
        do_read("to_cleared", 8'h10);

        do_write("w1c_go", 8'h14, 32'h3);
        repeat (2) @(negedge PCLK);
        ready = 1'b0;
        repeat (5) @(negedge PCLK);
        Dout = 32'hA5A5_0F0F;
        ready = 1'b1;
        do_write("w1c_same_edge", 8'h10, 32'h6);
        m_busy = 1'b0; m_rx = 32'hA5A5_0F0F; m_done = 1'b1;
        do_read("w1c_set_wins", 8'h10);
        do_write("w1c_clr", 8'h10, 32'h2);
        do_read("w1c_cleared", 8'h10);

        do_write("pr_con2", 8'h04, 32'h5A);
        do_write("pr_go", 8'h14, 32'h3);
        repeat (2) @(negedge PCLK);
        ready = 1'b0;
        repeat (5) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        model_reset();
        check("pr_con1", 32'(i2c_con1), 32'd0);
        check("pr_con2", 32'(i2c_con2), 32'd0);
        check("pr_din", Din, 32'd0);
        check("pr_irq", 32'(irq), 32'd0);
        PRESET = 1'b0;
        ready = 1'b1;
        for (int i = 0; i <= 20; i += 4) do_read("pr_rd", 8'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
